hygro_bcd_conv: RTL and testbench

Downstream converter for the Pmod HYGRO interface. It captures each new raw 14-bit temperature and humidity pair when the interface flags new data, then scales both to tenths of a unit (°C ×10, %RH ×10) with a sequential shift-add multiplier. It converts the results to packed BCD with an iterative double-dabble and presents them, with a sign flag, to the display or UART stages.

---
 rtl/hygro_bcd_conv.sv | 144 ++++++++++++++
 tb/tb_hygro_bcd_conv.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hygro_bcd_conv.sv
// Converts raw HDC1080 temperature/humidity codes to tenths-of-a-unit packed BCD.
// Flow: a serial shift-add multiply, one offset step, then a serial double-dabble.
module hygro_bcd_conv (
  input  logic        clk,
  input  logic        rst,
  input  logic        newData,
  input  logic [13:0] tem,
  input  logic [13:0] hum,
  output logic [15:0] tem_bcd,
  output logic        tem_neg,
  output logic [11:0] hum_bcd,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_ADJ, S_BCD, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;

  // Product registers: the high part accumulates, the low part holds the multiplier
  // bits not yet consumed and fills with product LSBs as it shifts right.
  logic [24:0] r_tp;
  logic [23:0] r_hp;
  logic [11:0] w_tsum;
  logic [10:0] w_hsum;

  logic [10:0] w_tq;
  logic [9:0]  w_hq;
  logic        w_tneg;
  logic [10:0] w_tmag;
  logic        r_tneg;

  // Double-dabble registers: {BCD digits, binary remainder}.
  logic [26:0] r_tsh;
  logic [22:0] r_hsh;
  logic [26:0] w_tadj;
  logic [22:0] w_hadj;

  logic [15:0] r_tem_bcd;
  logic [11:0] r_hum_bcd;
  logic        r_tem_neg;
  logic        r_valid;

  assign w_tsum = {1'b0, r_tp[24:14]} + (r_tp[0] ? 12'd1650 : 12'd0);
  assign w_hsum = {1'b0, r_hp[23:14]} + (r_hp[0] ? 11'd1000 : 11'd0);

  assign w_tq   = r_tp[24:14];
  assign w_hq   = r_hp[23:14];
  assign w_tneg = (w_tq < 11'd400);
  assign w_tmag = w_tneg ? (11'd400 - w_tq) : (w_tq - 11'd400);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_tnib
      assign w_tadj[11+4*gi +: 4] = (r_tsh[11+4*gi +: 4] >= 4'd5) ?
                                    (r_tsh[11+4*gi +: 4] + 4'd3) : r_tsh[11+4*gi +: 4];
    end
    for (gi = 0; gi < 3; gi++) begin : g_hnib
      assign w_hadj[11+4*gi +: 4] = (r_hsh[11+4*gi +: 4] >= 4'd5) ?
                                    (r_hsh[11+4*gi +: 4] + 4'd3) : r_hsh[11+4*gi +: 4];
    end
  endgenerate
  assign w_tadj[10:0] = r_tsh[10:0];
  assign w_hadj[10:0] = r_hsh[10:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (newData) w_state_next = S_MUL;
      S_MUL:   if (r_cnt == 4'd13) w_state_next = S_ADJ;
      S_ADJ:   w_state_next = S_BCD;
      S_BCD:   if (r_cnt == 4'd10) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= 4'd0;
      r_tp      <= 25'd0;
      r_hp      <= 24'd0;
      r_tneg    <= 1'b0;
      r_tsh     <= 27'd0;
      r_hsh     <= 23'd0;
      r_tem_bcd <= 16'd0;
      r_hum_bcd <= 12'd0;
      r_tem_neg <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if ((r_state == S_MUL || r_state == S_BCD) && (w_state_next == r_state)) begin
        r_cnt <= r_cnt + 4'd1;
      end else begin
        r_cnt <= 4'd0;
      end
      case (r_state)
        S_IDLE: begin
          if (newData) begin
            r_tp <= {11'd0, tem};
            r_hp <= {10'd0, hum};
          end
        end
        S_MUL: begin
          r_tp <= {w_tsum, r_tp[13:1]};
          r_hp <= {w_hsum, r_hp[13:1]};
        end
        S_ADJ: begin
          r_tneg <= w_tneg;
          r_tsh  <= {16'd0, w_tmag};
          r_hsh  <= {12'd0, 1'b0, w_hq};
        end
        S_BCD: begin
          r_tsh <= w_tadj << 1;
          r_hsh <= w_hadj << 1;
        end
        S_DONE: begin
          r_tem_bcd <= r_tsh[26:11];
          r_hum_bcd <= r_hsh[22:11];
          r_tem_neg <= r_tneg;
          r_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tem_bcd = r_tem_bcd;
  assign tem_neg = r_tem_neg;
  assign hum_bcd = r_hum_bcd;
  assign valid   = r_valid;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_hygro_bcd_conv.sv
// Self-checking bench for hygro_bcd_conv: directed vectors, random samples against an
// arithmetic model, dropped-pulse/back-to-back and mid-conversion reset sequences.
module tb_hygro_bcd_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        newData;
  logic [13:0] tem;
  logic [13:0] hum;
  logic [15:0] tem_bcd;
  logic        tem_neg;
  logic [11:0] hum_bcd;
  logic        valid;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] prev_tbcd;
  logic        prev_tneg;
  logic [11:0] prev_hbcd;

  typedef struct {
    logic [13:0] t;
    logic [13:0] h;
    logic [15:0] tbcd;
    logic        tneg;
    logic [11:0] hbcd;
  } vec_t;

  vec_t vecs[5];

  hygro_bcd_conv dut (
    .clk     (clk),
    .rst     (rst),
    .newData (newData),
    .tem     (tem),
    .hum     (hum),
    .tem_bcd (tem_bcd),
    .tem_neg (tem_neg),
    .hum_bcd (hum_bcd),
    .valid   (valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: straight arithmetic from the HDC1080 transfer functions, then decimal digits.
  task automatic model(input int t, input int h, output logic [15:0] tb,
                       output logic tn, output logic [11:0] hb);
    int tq, hq, m;
    tq = (t * 1650) / 16384;
    hq = (h * 1000) / 16384;
    tn = (tq < 400);
    m  = tn ? (400 - tq) : (tq - 400);
    tb = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    hb = {4'(hq / 100), 4'((hq / 10) % 10), 4'(hq % 10)};
  endtask

  // Caller has newData=1 with the sample on tem/hum; the next posedge is edge E.
  // drop_at>0 injects a second pulse after E+drop_at; chain=1 presents the next sample
  // right after E+27 so it is sampled at E+28, and returns with newData still high.
  task automatic conv(input logic [15:0] etb, input logic etn, input logic [11:0] ehb,
                      input int drop_at, input logic [13:0] dt, input logic [13:0] dh,
                      input bit chain, input logic [13:0] ct, input logic [13:0] ch);
    int nvalid;
    nvalid = 0;
    @(posedge clk);
    #1 newData = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      @(posedge clk);
      #1;
      if (valid) nvalid++;
      if (k == 1) chk("busy_start", busy, 1'b1);
      if (k < 27) begin
        chk("valid_early", valid, 1'b0);
        chk("hold_tbcd", tem_bcd, prev_tbcd);
      end
      if (k == 27) begin
        chk("valid_pulse", valid, 1'b1);
        chk("tem_bcd", tem_bcd, etb);
        chk("tem_neg", tem_neg, etn);
        chk("hum_bcd", hum_bcd, ehb);
        prev_tbcd = etb; prev_tneg = etn; prev_hbcd = ehb;
        if (chain) begin
          newData = 1'b1; tem = ct; hum = ch;
          break;
        end
      end
      if (k == 28) begin
        chk("valid_width", valid, 1'b0);
        chk("busy_end", busy, 1'b0);
        chk("hold_hbcd", hum_bcd, prev_hbcd);
      end
      if (drop_at > 0 && k == drop_at) begin
        newData = 1'b1; tem = dt; hum = dh;
      end
      if (drop_at > 0 && k == drop_at + 1) newData = 1'b0;
    end
    chk("valid_count", nvalid, 1);
    $display("conv -> tem_bcd=%04h neg=%0d hum_bcd=%03h valid_pulses=%0d",
             tem_bcd, tem_neg, hum_bcd, nvalid);
  endtask

  task automatic start(input logic [13:0] t, input logic [13:0] h);
    @(negedge clk);
    newData = 1'b1; tem = t; hum = h;
  endtask

  initial begin
    logic [15:0] etb;
    logic        etn;
    logic [11:0] ehb;
    int          nv;

    vecs[0] = '{14'h2000, 14'h2000, 16'h0425, 1'b0, 12'h500};
    vecs[1] = '{14'h0000, 14'h0000, 16'h0400, 1'b1, 12'h000};
    vecs[2] = '{14'h3FFF, 14'h3FFF, 16'h1249, 1'b0, 12'h999};
    vecs[3] = '{14'd3972, 14'h0000, 16'h0000, 1'b0, 12'h000};
    vecs[4] = '{14'd3971, 14'h2000, 16'h0001, 1'b1, 12'h500};

    rst = 1'b0; newData = 1'b0; tem = '0; hum = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tbcd", tem_bcd, 16'h0);
    chk("rst_tneg", tem_neg, 1'b0);
    chk("rst_hbcd", hum_bcd, 12'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    prev_tbcd = '0; prev_tneg = 1'b0; prev_hbcd = '0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      start(vecs[i].t, vecs[i].h);
      conv(vecs[i].tbcd, vecs[i].tneg, vecs[i].hbcd, 0, '0, '0, 1'b0, '0, '0);
    end

    for (int i = 0; i < 12; i++) begin
      logic [13:0] rt, rh;
      rt = 14'($urandom_range(0, 16383));
      rh = 14'($urandom_range(0, 16383));
      model(int'(rt), int'(rh), etb, etn, ehb);
      start(rt, rh);
      conv(etb, etn, ehb, 0, '0, '0, 1'b0, '0, '0);
    end

    // Pulse at E+6 dropped; third pulse at E+28 accepted.
    start(14'h2000, 14'h2000);
    conv(16'h0425, 1'b0, 12'h500, 5, 14'h0000, 14'h0000, 1'b1, 14'h3FFF, 14'h3FFF);
    conv(16'h1249, 1'b0, 12'h999, 0, '0, '0, 1'b0, '0, '0);

    // Reset at cycle 10 of a conversion.
    start(14'h0000, 14'h0000);
    @(posedge clk);
    #1 newData = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_tbcd", tem_bcd, 16'h0);
    chk("abort_hbcd", hum_bcd, 12'h0);
    chk("abort_busy", busy, 1'b0);
    rst = 1'b1;
    prev_tbcd = '0; prev_tneg = 1'b0; prev_hbcd = '0;
    nv = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1 if (valid) nv++;
    end
    chk("abort_no_valid", nv, 0);
    $display("abort -> valid_pulses=%0d busy=%0d", nv, busy);
    start(14'd3971, 14'h3FFF);
    conv(16'h0001, 1'b1, 12'h999, 0, '0, '0, 1'b0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
